fetch_stage: RTL

Instruction-fetch stage of the RISC-V core. It sits directly upstream of pipeline_registers and drives its if_pc, if_instruction and if_valid inputs.
It holds the PC, issues word requests to instruction memory over a valid/ready request channel, and receives in-order responses. Fetched words are buffered in a small in-order queue so that hazard stalls never lose data. Branch/jump redirects discard all wrong-path fetches.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_queue.sv | 78 +++++++
 rtl/fetch_stage.sv | 84 ++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage: word width, NOP
// encoding, reset vector and the fetch-queue entry layout.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel plus in-order,
// always-accepted response channel.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at the tail, filled oldest
// unfilled first and popped from the head; flush frees everything at once.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fq_entry_t              head,
  output logic                   has_unfilled,
  output logic [$clog2(DEPTH):0] unfilled_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [PW-1:0]   fill_ptr;
  logic            fill_ok;

  assign has_unfilled = (unfilled_cnt != '0);
  assign fill_ok      = fill && has_unfilled;
  // Unfilled entries are always the youngest ones, so the oldest sits just
  // behind the tail; a full count truncates to 0 and lands on the head.
  assign fill_ptr     = tail_ptr - PW'(unfilled_cnt);

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      count        <= '0;
      unfilled_cnt <= '0;
      filled_q     <= '0;
    end else if (flush) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      count        <= '0;
      unfilled_cnt <= '0;
      filled_q     <= '0;
    end else begin
      if (alloc) begin
        filled_q[tail_ptr] <= 1'b0;
        tail_ptr           <= tail_ptr + PW'(1);
      end
      if (fill_ok) filled_q[fill_ptr] <= 1'b1;
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      count        <= count + CW'(alloc) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(fill_ok);
    end
  end

  // NOTE: payload arrays are not reset; count and filled bits alone decide validity.
  always_ff @(posedge clk) begin
    if (alloc)   pc_q[tail_ptr]   <= alloc_pc;
    if (fill_ok) data_q[fill_ptr] <= fill_data;
  end

  assign head = '{pc:     pc_q[head_ptr],
                  data:   data_q[head_ptr],
                  filled: filled_q[head_ptr] && (count != '0)};

endmodule

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: PC register, request gating, wrong-path
// response dropping and the hand-off of the queue head to pipeline_registers.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_instruction,
  output logic             if_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_unfilled;
  logic            q_has_unfilled;
  fq_entry_t       q_head;
  logic            accept;
  logic            resp_drop;
  logic            resp_fill;
  logic            resp_consumed;
  logic            pop;

  assign imem.imem_req_valid = !reset && !redirect && (q_count < CW'(DEPTH));
  assign imem.imem_addr      = pc;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  assign resp_drop     = imem.imem_resp_valid && (drop_cnt != '0);
  assign resp_fill     = imem.imem_resp_valid && (drop_cnt == '0) && !redirect;
  // A response in the redirect cycle retires one outstanding request whether it
  // would have been dropped or would have filled an entry that is now flushed.
  assign resp_consumed = imem.imem_resp_valid && ((drop_cnt != '0) || q_has_unfilled);

  assign if_valid       = q_head.filled;
  assign if_pc          = if_valid ? q_head.pc   : '0;
  assign if_instruction = if_valid ? q_head.data : NOP_INSTR;
  assign pop            = if_valid && !stall && !redirect;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .flush        (redirect),
    .alloc        (accept),
    .alloc_pc     (pc),
    .fill         (resp_fill),
    .fill_data    (imem.imem_resp_data),
    .pop          (pop),
    .count        (q_count),
    .head         (q_head),
    .has_unfilled (q_has_unfilled),
    .unfilled_cnt (q_unfilled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (accept)   pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          drop_cnt <= '0;
    else if (redirect)  drop_cnt <= drop_cnt + q_unfilled - CW'(resp_consumed);
    else if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
  end

  always @(posedge clk) begin
    if (!reset) begin
      resp_has_target: assert (!imem.imem_resp_valid || (drop_cnt != '0) || q_has_unfilled)
        else $error("fetch_stage: instruction response with no outstanding request");
    end
  end

endmodule
